// File: rtl/cache_alloc_arbiter_pkg.sv
// Shared cache properties: geometry, address field positions,
// allocate port bundles and the allocation-arbiter FSM states.
package cache_alloc_arbiter_pkg;

    localparam int MSHR_SIZE   = 8;
    localparam int CL_SIZE     = 64;
    localparam int NUM_OF_WAYS = 4;
    localparam int NUM_OF_SETS = 64;
    localparam int RETRY_WAIT  = 4;
    localparam int PADDR_WIDTH = 32;

    localparam int CL_OFFSET_WIDTH = $clog2(CL_SIZE);
    localparam int CL_OFFSET_LSB   = 0;
    localparam int CL_OFFSET_MSB   = CL_OFFSET_WIDTH - 1;
    localparam int SET_IDX_WIDTH   = $clog2(NUM_OF_SETS);
    localparam int SET_IDX_LSB     = CL_OFFSET_WIDTH;
    localparam int SET_IDX_MSB     = SET_IDX_LSB + SET_IDX_WIDTH - 1;
    localparam int WAY_IDX_WIDTH   = $clog2(NUM_OF_WAYS);
    localparam int MSHR_IDX_WIDTH  = $clog2(MSHR_SIZE);
    localparam int RETRY_CNT_WIDTH = $clog2(RETRY_WAIT + 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RES = 1'b1
    } alloc_arb_state_t;

    typedef struct packed {
        logic                      valid;
        logic [PADDR_WIDTH-1:0]    paddr_cl_aligned;
        logic [MSHR_IDX_WIDTH-1:0] mshr_idx;
        logic [SET_IDX_WIDTH-1:0]  set_idx;
    } allocate_req_t;

    typedef struct packed {
        logic                      valid;
        logic                      success;
        logic [MSHR_IDX_WIDTH-1:0] mshr_idx;
        logic [WAY_IDX_WIDTH-1:0]  way_idx;
        logic                      wb_need;
        logic [PADDR_WIDTH-1:0]    paddr_cl_aligned_prev;
    } allocate_res_t;

    function automatic logic [PADDR_WIDTH-1:0] cl_align(
        input logic [PADDR_WIDTH-1:0] paddr
    );
        cl_align = {paddr[PADDR_WIDTH-1:CL_OFFSET_WIDTH],
                    {CL_OFFSET_WIDTH{1'b0}}};
    endfunction

    function automatic logic [SET_IDX_WIDTH-1:0] set_of(
        input logic [PADDR_WIDTH-1:0] paddr
    );
        set_of = paddr[SET_IDX_MSB:SET_IDX_LSB];
    endfunction

endpackage

// File: rtl/cache_alloc_arbiter_rr_picker.sv
// Combinational round-robin first-set search over a request vector.
// Ports: req (N), ptr (start index) -> gnt_idx, gnt_any.
module rr_picker #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan from the farthest offset back to ptr so the closest
    // set bit at or after ptr is the one left standing.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt_idx = IW'((int'(ptr) + i) % N);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_alloc_arbiter.sv
// Shares the cache-buffer allocate port among MSHR entries, round-robin,
// one request in flight, per-entry back-off after a failed allocation.
// Ports: clk, rst_n (sync, active-low); mshr_req_valid/paddr in;
// mshr_done_* out; allocate_req out / allocate_res in; busy out.
module cache_alloc_arbiter
    import cache_alloc_arbiter_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [MSHR_SIZE-1:0]               mshr_req_valid,
    input  logic [MSHR_SIZE*PADDR_WIDTH-1:0]   mshr_req_paddr,
    output logic [MSHR_SIZE-1:0]               mshr_done_valid,
    output logic [WAY_IDX_WIDTH-1:0]           mshr_done_way_idx,
    output logic                               mshr_done_wb_need,
    output logic [PADDR_WIDTH-1:0]             mshr_done_paddr_prev,
    output allocate_req_t                      allocate_req,
    input  allocate_res_t                      allocate_res,
    output logic                               busy
);

    alloc_arb_state_t state;
    alloc_arb_state_t state_next;

    logic [MSHR_IDX_WIDTH-1:0]  grant;
    logic [MSHR_IDX_WIDTH-1:0]  grant_inc;
    logic [MSHR_IDX_WIDTH-1:0]  rr_ptr;
    logic [RETRY_CNT_WIDTH-1:0] retry_cnt [MSHR_SIZE];

    logic [MSHR_SIZE-1:0]       eligible;
    logic [MSHR_IDX_WIDTH-1:0]  pick_idx;
    logic                       pick_any;
    logic [PADDR_WIDTH-1:0]     pick_paddr;

    logic res_match;
    logic issue;
    logic res_ok;
    logic res_fail;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            eligible[i] = mshr_req_valid[i] && (retry_cnt[i] == '0);
        end
    end

    rr_picker #(
        .N  (MSHR_SIZE),
        .IW (MSHR_IDX_WIDTH)
    ) u_rr_picker (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign pick_paddr =
        mshr_req_paddr[pick_idx*PADDR_WIDTH +: PADDR_WIDTH];
    assign res_match = allocate_res.valid &&
                       (allocate_res.mshr_idx == grant);
    assign grant_inc = (grant == MSHR_IDX_WIDTH'(MSHR_SIZE - 1)) ?
                       '0 : grant + 1'b1;
    assign busy = (state == WAIT_RES);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        res_ok     = 1'b0;
        res_fail   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    issue      = 1'b1;
                    state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_match) begin
                    state_next = IDLE;
                    res_ok     = allocate_res.success;
                    res_fail   = !allocate_res.success;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            grant                <= '0;
            rr_ptr               <= '0;
            allocate_req         <= '0;
            mshr_done_valid      <= '0;
            mshr_done_way_idx    <= '0;
            mshr_done_wb_need    <= 1'b0;
            mshr_done_paddr_prev <= '0;
            for (int i = 0; i < MSHR_SIZE; i++) begin
                retry_cnt[i] <= '0;
            end
        end else begin
            state                <= state_next;
            allocate_req         <= '0;
            mshr_done_valid      <= '0;
            mshr_done_way_idx    <= '0;
            mshr_done_wb_need    <= 1'b0;
            mshr_done_paddr_prev <= '0;
            if (issue) begin
                grant                         <= pick_idx;
                allocate_req.valid            <= 1'b1;
                allocate_req.paddr_cl_aligned <= cl_align(pick_paddr);
                allocate_req.mshr_idx         <= pick_idx;
                allocate_req.set_idx          <= set_of(pick_paddr);
            end
            if (res_ok || res_fail) begin
                rr_ptr <= grant_inc;
            end
            if (res_ok) begin
                mshr_done_valid[grant] <= 1'b1;
                mshr_done_way_idx      <= allocate_res.way_idx;
                mshr_done_wb_need      <= allocate_res.wb_need;
                mshr_done_paddr_prev   <=
                    allocate_res.paddr_cl_aligned_prev;
            end
            // A fresh back-off wins over the running decrement.
            for (int i = 0; i < MSHR_SIZE; i++) begin
                if (res_fail && grant == MSHR_IDX_WIDTH'(i)) begin
                    retry_cnt[i] <= RETRY_CNT_WIDTH'(RETRY_WAIT);
                end else if (retry_cnt[i] != '0) begin
                    retry_cnt[i] <= retry_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Responses addressed to another entry are dropped; make them visible.
    res_idx_match: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(state == WAIT_RES && allocate_res.valid &&
          allocate_res.mshr_idx != grant)
    ) else $warning("allocate_res for mshr %0d dropped, waiting on %0d",
                    allocate_res.mshr_idx, grant);

endmodule

// File: tb/tb_cache_alloc_arbiter.sv
// Bench for cache_alloc_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_cache_alloc_arbiter;
    import cache_alloc_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [MSHR_SIZE-1:0]             req_v;
    logic [PADDR_WIDTH-1:0]           paddr [MSHR_SIZE];
    logic [MSHR_SIZE*PADDR_WIDTH-1:0] paddr_flat;
    logic [MSHR_SIZE-1:0]             done_v;
    logic [WAY_IDX_WIDTH-1:0]         done_way;
    logic                             done_wb;
    logic [PADDR_WIDTH-1:0]           done_prev;
    allocate_req_t                    a_req;
    allocate_res_t                    a_res;
    logic                             busy;

    always_comb begin
        paddr_flat = '0;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            paddr_flat[i*PADDR_WIDTH +: PADDR_WIDTH] = paddr[i];
        end
    end

    cache_alloc_arbiter dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mshr_req_valid       (req_v),
        .mshr_req_paddr       (paddr_flat),
        .mshr_done_valid      (done_v),
        .mshr_done_way_idx    (done_way),
        .mshr_done_wb_need    (done_wb),
        .mshr_done_paddr_prev (done_prev),
        .allocate_req         (a_req),
        .allocate_res         (a_res),
        .busy                 (busy)
    );

    typedef struct {
        logic                      rv;
        logic [MSHR_IDX_WIDTH-1:0] ri;
        logic [PADDR_WIDTH-1:0]    pa;
        logic [SET_IDX_WIDTH-1:0]  set;
        logic [MSHR_SIZE-1:0]      done;
        logic [WAY_IDX_WIDTH-1:0]  way;
        logic                      wb;
        logic [PADDR_WIDTH-1:0]    prev;
        logic                      busy;
    } exp_t;

    typedef struct {
        logic                      rst;
        logic [MSHR_SIZE-1:0]      rq;
        logic                      rv;
        logic                      rs;
        logic [MSHR_IDX_WIDTH-1:0] ri;
        logic [WAY_IDX_WIDTH-1:0]  way;
        logic                      wb;
        logic [PADDR_WIDTH-1:0]    prev;
        exp_t                      e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t zexp();
        exp_t e;
        e.rv = 0; e.ri = 0; e.pa = 0; e.set = 0; e.done = 0;
        e.way = 0; e.wb = 0; e.prev = 0; e.busy = 0;
        return e;
    endfunction

    task automatic chk_out(input string tag, input exp_t e,
                           input bit full);
        chk({tag, ".req_valid"}, 64'(a_req.valid), 64'(e.rv));
        if (full || e.rv) begin
            chk({tag, ".req_idx"}, 64'(a_req.mshr_idx), 64'(e.ri));
            chk({tag, ".req_paddr"},
                64'(a_req.paddr_cl_aligned), 64'(e.pa));
            chk({tag, ".req_set"}, 64'(a_req.set_idx), 64'(e.set));
        end
        chk({tag, ".done_valid"}, 64'(done_v), 64'(e.done));
        if (full || e.done != 0) begin
            chk({tag, ".done_way"}, 64'(done_way), 64'(e.way));
            chk({tag, ".done_wb"}, 64'(done_wb), 64'(e.wb));
            chk({tag, ".done_prev"}, 64'(done_prev), 64'(e.prev));
        end
        chk({tag, ".busy"}, 64'(busy), 64'(e.busy));
    endtask

    // Drive inputs for the next edge, then settle 1 time unit past it.
    task automatic apply(input logic rst,
                         input logic [MSHR_SIZE-1:0] rq,
                         input logic rv, input logic rs,
                         input logic [MSHR_IDX_WIDTH-1:0] ri,
                         input logic [WAY_IDX_WIDTH-1:0] way,
                         input logic wb,
                         input logic [PADDR_WIDTH-1:0] prev);
        rst_n = rst;
        req_v = rq;
        a_res.valid = rv;
        a_res.success = rs;
        a_res.mshr_idx = ri;
        a_res.way_idx = way;
        a_res.wb_need = wb;
        a_res.paddr_cl_aligned_prev = prev;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic rst, input logic [MSHR_SIZE-1:0] rq);
        apply(rst, rq, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resp(input logic [MSHR_SIZE-1:0] rq,
                        input logic [MSHR_IDX_WIDTH-1:0] ri,
                        input logic ok);
        apply(1, rq, 1, ok, ri, 2'd1, 1'b0, 32'h0000_0C40);
    endtask

    function automatic vec_t v(
        input logic rst, input logic [7:0] rq, input logic rv,
        input logic rs, input logic [2:0] ri, input logic [1:0] way,
        input logic wb, input logic [31:0] prev,
        input logic erv, input logic [2:0] eri, input logic [31:0] epa,
        input logic [5:0] eset, input logic [7:0] edone,
        input logic [1:0] eway, input logic ewb, input logic [31:0] eprev,
        input logic ebusy);
        vec_t r;
        r.rst = rst; r.rq = rq; r.rv = rv; r.rs = rs; r.ri = ri;
        r.way = way; r.wb = wb; r.prev = prev;
        r.e.rv = erv; r.e.ri = eri; r.e.pa = epa; r.e.set = eset;
        r.e.done = edone; r.e.way = eway; r.e.wb = ewb;
        r.e.prev = eprev; r.e.busy = ebusy;
        return r;
    endfunction

    vec_t tbl [23];

    // Random-phase state
    logic [MSHR_SIZE-1:0]      rq;
    logic                      rv, rs, rwb;
    logic [MSHR_IDX_WIDTH-1:0] rri;
    logic [WAY_IDX_WIDTH-1:0]  rway;
    logic [PADDR_WIDTH-1:0]    rprev;
    exp_t                      e;
    int                        m_rr, m_pend, m_wait, j, n;
    int                        blocked [MSHR_SIZE];

    initial begin
        for (int i = 0; i < MSHR_SIZE; i++) begin
            paddr[i] = 32'(i) * 32'h1000_0040 + 32'd7;
        end
        paddr[3] = 32'h8000_1234;
        req_v = '0;
        a_res = '0;

        tbl[0]  = v(0,8'h00,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
        tbl[1]  = v(1,8'h08,0,0,0,0,0,0,
                    1,3,32'h8000_1200,6'h08,8'h00,0,0,0,1);
        tbl[2]  = v(1,8'h08,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,1);
        tbl[3]  = v(1,8'h08,1,1,3,2,1,32'h4000_1200,
                    0,0,0,0,8'h08,2,1,32'h4000_1200,0);
        tbl[4]  = v(1,8'h00,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
        tbl[5]  = v(1,8'h04,0,0,0,0,0,0,
                    1,2,32'h2000_0080,6'h02,8'h00,0,0,0,1);
        tbl[6]  = v(1,8'h04,1,1,6,1,0,0, 0,0,0,0,8'h00,0,0,0,1);
        tbl[7]  = v(1,8'h04,1,1,2,3,0,32'h1234_5600,
                    0,0,0,0,8'h04,3,0,32'h1234_5600,0);
        tbl[8]  = v(0,8'h00,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
        tbl[9]  = v(1,8'h25,0,0,0,0,0,0,
                    1,0,32'h0000_0000,6'h00,8'h00,0,0,0,1);
        tbl[10] = v(1,8'h25,1,1,0,1,0,32'h0ABC_0000,
                    0,0,0,0,8'h01,1,0,32'h0ABC_0000,0);
        tbl[11] = v(1,8'h24,0,0,0,0,0,0,
                    1,2,32'h2000_0080,6'h02,8'h00,0,0,0,1);
        tbl[12] = v(1,8'h24,1,1,2,0,1,32'h0000_1000,
                    0,0,0,0,8'h04,0,1,32'h0000_1000,0);
        tbl[13] = v(1,8'h20,0,0,0,0,0,0,
                    1,5,32'h5000_0140,6'h05,8'h00,0,0,0,1);
        tbl[14] = v(1,8'h20,1,1,5,3,1,32'hFFFF_FFC0,
                    0,0,0,0,8'h20,3,1,32'hFFFF_FFC0,0);
        tbl[15] = v(1,8'h41,0,0,0,0,0,0,
                    1,6,32'h6000_0180,6'h06,8'h00,0,0,0,1);
        tbl[16] = v(1,8'h41,1,0,6,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
        tbl[17] = v(1,8'h41,0,0,0,0,0,0,
                    1,0,32'h0000_0000,6'h00,8'h00,0,0,0,1);
        tbl[18] = v(1,8'h41,1,1,0,2,0,0, 0,0,0,0,8'h01,2,0,0,0);
        tbl[19] = v(1,8'h40,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
        tbl[20] = v(1,8'h40,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
        tbl[21] = v(1,8'h40,0,0,0,0,0,0,
                    1,6,32'h6000_0180,6'h06,8'h00,0,0,0,1);
        tbl[22] = v(1,8'h00,1,1,6,1,1,32'h0000_0040,
                    0,0,0,0,8'h40,1,1,32'h0000_0040,0);

        for (int r = 0; r < 23; r++) begin
            apply(tbl[r].rst, tbl[r].rq, tbl[r].rv, tbl[r].rs,
                  tbl[r].ri, tbl[r].way, tbl[r].wb, tbl[r].prev);
            chk_out($sformatf("vec%0d", r), tbl[r].e, !tbl[r].rst);
        end

        // Entry 1 fails while entry 4 waits; 1 returns after back-off.
        tick(0, 8'h00);
        tick(1, 8'h12);
        chk("bo.grant1", 64'(a_req.mshr_idx), 64'd1);
        resp(8'h12, 3'd1, 1'b0);
        chk("bo.fail_done", 64'(done_v), 64'd0);
        tick(1, 8'h12);
        chk("bo.grant4_valid", 64'(a_req.valid), 64'd1);
        chk("bo.grant4_idx", 64'(a_req.mshr_idx), 64'd4);
        resp(8'h12, 3'd4, 1'b1);
        chk("bo.done4", 64'(done_v), 64'h10);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1, 8'h02);
            n++;
            if (a_req.valid) break;
        end
        chk("bo.regrant_delay", 64'(n), 64'd3);
        chk("bo.regrant_idx", 64'(a_req.mshr_idx), 64'd1);

        // Reset while waiting, late response afterwards.
        tick(0, 8'h00);
        tick(1, 8'h08);
        resp(8'h08, 3'd3, 1'b1);
        chk("rst.pre_done", 64'(done_v), 64'h08);
        tick(1, 8'h20);
        chk("rst.grant5", 64'(a_req.mshr_idx), 64'd5);
        tick(0, 8'h20);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.req_valid", 64'(a_req.valid), 64'd0);
        resp(8'h00, 3'd5, 1'b1);
        chk("rst.late_done", 64'(done_v), 64'd0);
        chk("rst.late_busy", 64'(busy), 64'd0);
        tick(1, 8'h28);
        chk("rst.first_valid", 64'(a_req.valid), 64'd1);
        chk("rst.first_idx", 64'(a_req.mshr_idx), 64'd3);

        // Pointer wrap after entry 7.
        tick(0, 8'h00);
        tick(1, 8'h80);
        chk("wrap.grant7", 64'(a_req.mshr_idx), 64'd7);
        resp(8'h80, 3'd7, 1'b1);
        chk("wrap.done7", 64'(done_v), 64'h80);
        tick(1, 8'h81);
        chk("wrap.grant0", 64'(a_req.mshr_idx), 64'd0);
        resp(8'h81, 3'd0, 1'b1);
        chk("wrap.done0", 64'(done_v), 64'h01);
        tick(1, 8'h80);
        chk("wrap.regrant7_valid", 64'(a_req.valid), 64'd1);
        chk("wrap.regrant7_idx", 64'(a_req.mshr_idx), 64'd7);

        // Randomized traffic against a transaction-level model. An entry
        // failing at edge k may be picked again from edge k+RETRY_WAIT+1.
        tick(0, 8'h00);
        m_rr = 0;
        m_pend = -1;
        m_wait = 0;
        rq = '0;
        for (int i = 0; i < MSHR_SIZE; i++) blocked[i] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < MSHR_SIZE; i++) begin
                if (!rq[i] && $urandom_range(0, 5) == 0) begin
                    rq[i] = 1'b1;
                    paddr[i] = $urandom;
                end else if (rq[i] && $urandom_range(0, 39) == 0) begin
                    rq[i] = 1'b0;
                end
            end
            rv = 0; rs = 0; rri = 0; rway = 0; rwb = 0; rprev = 0;
            if (m_pend >= 0) begin
                if (m_wait <= 1) begin
                    rv = 1;
                    rs = ($urandom_range(0, 3) != 0);
                    rri = MSHR_IDX_WIDTH'(m_pend);
                    rway = WAY_IDX_WIDTH'($urandom);
                    rwb = 1'($urandom);
                    rprev = $urandom & ~32'(CL_SIZE - 1);
                end else begin
                    m_wait--;
                end
            end
            e = zexp();
            if (m_pend < 0) begin
                for (int o = 0; o < MSHR_SIZE; o++) begin
                    j = (m_rr + o) % MSHR_SIZE;
                    if (rq[j] && k >= blocked[j]) begin
                        e.rv = 1;
                        e.ri = MSHR_IDX_WIDTH'(j);
                        e.pa = paddr[j] & ~32'(CL_SIZE - 1);
                        e.set = SET_IDX_WIDTH'(
                            (paddr[j] / CL_SIZE) % NUM_OF_SETS);
                        m_pend = j;
                        m_wait = $urandom_range(1, 3);
                        break;
                    end
                end
            end else if (rv) begin
                if (rs) begin
                    e.done = MSHR_SIZE'(1) << m_pend;
                    e.way = rway;
                    e.wb = rwb;
                    e.prev = rprev;
                end else begin
                    blocked[m_pend] = k + RETRY_WAIT + 1;
                end
                m_rr = (m_pend + 1) % MSHR_SIZE;
                m_pend = -1;
            end
            e.busy = (m_pend >= 0);
            apply(1, rq, rv, rs, rri, rway, rwb, rprev);
            chk_out($sformatf("rand%0d", k), e, 1'b0);
            rq = rq & ~e.done;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
